// File: rtl/icache_sa_if.sv
// L2 line-fill bus between icache_sa (master) and the L2 (slave).
interface icache_sa_if #(
  parameter int unsigned AW = 58,
  parameter int unsigned LW = 256
);
  logic [AW-1:0] b_addr_o;
  logic          b_rd_o;
  logic [LW-1:0] b_data_i;
  logic          b_dv_i;

  modport master (output b_addr_o, output b_rd_o, input b_data_i, input b_dv_i);
  modport slave  (input b_addr_o, input b_rd_o, output b_data_i, output b_dv_i);
endinterface

// File: rtl/icache_sa.sv
// Parametrised set-associative L1 I-cache: tree-PLRU, one-line read buffer, straddle fetch,
// whole-cache flush. Define ICACHE_PERF_CNT_EN to add hit_cnt/miss_cnt outputs.
module icache_sa #(
  parameter int unsigned WAYS      = 4,
  parameter int unsigned SETS      = 64,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [63:0]       pc,
  output logic [31:0]       ir,
  output logic              stall_o,
  input  logic              flush_i,
  icache_sa_if.master       bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [63:0]       hit_cnt,
  output logic [63:0]       miss_cnt
`endif
);
  localparam int unsigned LINE_BYTES = LINE_BITS / 8;
  localparam int unsigned OFFS       = $clog2(LINE_BYTES);
  localparam int unsigned SETW       = $clog2(SETS);
  localparam int unsigned TAGW       = 64 - SETW - OFFS;
  localparam int unsigned LAW        = TAGW + SETW;
  localparam int unsigned LVLS       = $clog2(WAYS);
  localparam int unsigned WAYW       = (LVLS > 0) ? LVLS : 1;
  localparam int unsigned PW         = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {StReady, StRdata, StFetch} state_e;

  state_e state_q, state_d;

  logic [TAGW-1:0]      tag_q   [SETS][WAYS];
  logic [WAYS-1:0]      valid_q [SETS];
  logic [LINE_BITS-1:0] mem_q   [SETS*WAYS];
  logic [LINE_BITS-1:0] ram_rdata_q;

  logic                 lb_valid_q;
  logic [LAW-1:0]       lb_addr_q;
  logic [LINE_BITS-1:0] lb_data_q;
  logic                 split_q;
  logic [15:0]          half_q;
  logic                 fl_pend_q;
  logic [LAW-1:0]       b_addr_q;
  logic [LAW-1:0]       line_q;
  logic [WAYW-1:0]      way_q;

  // Tree walk: node n has children 2n+1 / 2n+2; a 0 bit points at the left (older) side.
  function automatic logic [WAYW-1:0] plru_victim(input logic [PW-1:0] t);
    logic [WAYW-1:0] w;
    int unsigned     node;
    logic            b;
    w    = '0;
    node = 0;
    for (int unsigned l = 0; l < LVLS; l++) begin
      b = 1'b0;
      for (int unsigned n = 0; n < PW; n++) if (n == node) b = t[n];
      w    = (w << 1) | WAYW'(b);
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WAYW-1:0] w);
    logic [PW-1:0] r;
    int unsigned   node;
    logic          b;
    r    = t;
    node = 0;
    for (int unsigned l = 0; l < LVLS; l++) begin
      b = w[LVLS-1-l];
      for (int unsigned n = 0; n < PW; n++) if (n == node) r[n] = ~b;
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    return r;
  endfunction

  logic [LAW-1:0]  pc_line, lk_line;
  logic [OFFS-1:0] offs;
  logic [SETW-1:0] lk_set, set_q;
  logic [TAGW-1:0] lk_tag;
  logic            straddle, lb_hit, split_done, split_cap, serve;
  logic            tag_hit, inv_found;
  logic [WAYW-1:0] hit_way, inv_way, plru_vic, victim;
  logic            go_rd, go_fetch, rd_done, fill_ok, fill_flush, do_flush;
  logic [LINE_BITS-1:0] lb_shift;

  assign pc_line    = pc[63:OFFS];
  assign offs       = pc[OFFS-1:0];
  assign straddle   = (offs == OFFS'(LINE_BYTES - 2));
  assign lb_hit     = !straddle && lb_valid_q && (lb_addr_q == pc_line);
  assign split_done = straddle && split_q && lb_valid_q && (lb_addr_q == pc_line + LAW'(1));
  assign split_cap  = straddle && !split_q && lb_valid_q && (lb_addr_q == pc_line);
  assign serve      = lb_hit || split_done;
  // A straddle with its lower half already in hand looks up the following line.
  assign lk_line    = (straddle && (split_q || split_cap)) ? pc_line + LAW'(1) : pc_line;
  assign lk_set     = lk_line[SETW-1:0];
  assign lk_tag     = lk_line[LAW-1:SETW];
  assign set_q      = line_q[SETW-1:0];

  always_comb begin
    tag_hit   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
        tag_hit = 1'b1;
        hit_way = WAYW'(w);
      end
      if (!valid_q[lk_set][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAYW'(w);
      end
    end
  end

  assign victim     = inv_found ? inv_way : plru_vic;
  assign go_rd      = (state_q == StReady) && !serve && !flush_i && tag_hit;
  assign go_fetch   = (state_q == StReady) && !serve && !flush_i && !tag_hit;
  assign rd_done    = (state_q == StRdata) && !flush_i;
  assign fill_ok    = (state_q == StFetch) && bus.b_dv_i && !fl_pend_q && !flush_i;
  assign fill_flush = (state_q == StFetch) && bus.b_dv_i && (fl_pend_q || flush_i);
  assign do_flush   = fill_flush || (flush_i && (state_q != StFetch));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StReady;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReady: begin
        if (go_rd)         state_d = StRdata;
        else if (go_fetch) state_d = StFetch;
      end
      StRdata: state_d = StReady;
      StFetch: if (bus.b_dv_i) state_d = StReady;
      default: state_d = StReady;
    endcase
  end

  always_comb begin
    lb_shift   = lb_data_q >> {offs, 3'b000};
    stall_o    = !((state_q == StReady) && serve);
    bus.b_rd_o = (state_q == StFetch);
    ir         = '0;
    if (split_done)                  ir = {lb_data_q[15:0], half_q};
    else if (lb_valid_q && !straddle) ir = lb_shift[31:0];
  end

  assign bus.b_addr_o = b_addr_q;

  if (WAYS > 1) begin : g_plru
    logic [PW-1:0] plru_q [SETS];
    assign plru_vic = plru_victim(plru_q[lk_set]);
    always_ff @(posedge clk) begin
      if (!rst_n || do_flush) begin
        for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (fill_ok || rd_done) begin
        plru_q[set_q] <= plru_touch(plru_q[set_q], way_q);
      end
    end
  end else begin : g_no_plru
    assign plru_vic = '0;
  end

  logic [SETW+LVLS-1:0] fill_idx, rd_idx;
  if (WAYS > 1) begin : g_idx_assoc
    assign fill_idx = {set_q, way_q};
    assign rd_idx   = {lk_set, hit_way};
  end else begin : g_idx_dm
    assign fill_idx = set_q;
    assign rd_idx   = lk_set;
  end

  always_ff @(posedge clk) begin
    if (fill_ok) mem_q[fill_idx] <= bus.b_data_i;
    if (go_rd)   ram_rdata_q     <= mem_q[rd_idx];
    if (fill_ok) tag_q[set_q][way_q] <= line_q[LAW-1:SETW];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || do_flush) begin
      for (int unsigned s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else if (fill_ok) begin
      valid_q[set_q][way_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lb_valid_q <= 1'b0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
      split_q    <= 1'b0;
      half_q     <= '0;
      fl_pend_q  <= 1'b0;
      b_addr_q   <= '0;
      line_q     <= '0;
      way_q      <= '0;
    end else begin
      if (go_rd) begin
        line_q <= lk_line;
        way_q  <= hit_way;
      end
      if (go_fetch) begin
        line_q   <= lk_line;
        way_q    <= victim;
        b_addr_q <= lk_line;
      end
      fl_pend_q <= (state_q == StFetch) && (fl_pend_q || flush_i) && !bus.b_dv_i;
      if (do_flush) begin
        lb_valid_q <= 1'b0;
      end else if (fill_ok) begin
        lb_valid_q <= 1'b1;
        lb_addr_q  <= line_q;
        lb_data_q  <= bus.b_data_i;
      end else if (rd_done) begin
        lb_valid_q <= 1'b1;
        lb_addr_q  <= line_q;
        lb_data_q  <= ram_rdata_q;
      end
      if (do_flush) begin
        split_q <= 1'b0;
      end else if (state_q == StReady) begin
        if (split_cap) begin
          split_q <= 1'b1;
          half_q  <= lb_data_q[LINE_BITS-1 -: 16];
        end else if (serve) begin
          split_q <= 1'b0;
        end
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [63:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (go_rd)    hit_cnt_q  <= hit_cnt_q + 64'd1;
      if (go_fetch) miss_cnt_q <= miss_cnt_q + 64'd1;
    end
  end
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa (4 ways, 64 sets, 256-bit lines) with a 2-cycle L2 responder.
module tb_icache_sa;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] ir;
  logic        stall_o;
  logic        flush_i = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [63:0] hit_cnt, miss_cnt;
`endif

  icache_sa_if #(.AW(58), .LW(256)) bus ();

  icache_sa #(.WAYS(4), .SETS(64), .LINE_BITS(256)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc      (pc),
    .ir      (ir),
    .stall_o (stall_o),
    .flush_i (flush_i),
    .bus     (bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          addr_moved = 0;
  int          wcnt = 0;
  logic [57:0] first_addr;
  logic [57:0] rd_log [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] make_line(input logic [57:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = {la[15:0], 8'h5A, 8'(i)};
    if (la == 58'h80) l[31:0] = 32'h0050_0093;
    return l;
  endfunction

  function automatic logic [31:0] exp_ir(input logic [63:0] a);
    logic [255:0] l0, l1;
    logic [57:0]  la;
    int           off;
    la  = a[63:5];
    off = int'(a[4:0]);
    l0  = make_line(la);
    l1  = make_line(la + 58'd1);
    if (off == 30) return {l1[15:0], l0[255:240]};
    return l0[off*8 +: 32];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // L2 model: answers each request two cycles after b_rd_o is first seen.
  initial begin
    bus.b_dv_i   = 1'b0;
    bus.b_data_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.b_dv_i) begin
        bus.b_dv_i = 1'b0;
        wcnt = 0;
      end else if (bus.b_rd_o) begin
        if (wcnt == 0) first_addr = bus.b_addr_o;
        wcnt++;
        if (wcnt >= 2) begin
          if (bus.b_addr_o !== first_addr) addr_moved++;
          bus.b_data_i = make_line(bus.b_addr_o);
          bus.b_dv_i   = 1'b1;
          rd_log.push_back(bus.b_addr_o);
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic do_reset(input string tag);
    rst_n   = 1'b0;
    flush_i = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    #1;
    check_eq({tag, "_rd"}, 64'(bus.b_rd_o), 64'd0);
    check_eq({tag, "_addr"}, 64'(bus.b_addr_o), 64'd0);
    check_eq({tag, "_ir"}, 64'(ir), 64'd0);
  endtask

  // exp_stalls < 0 skips the stall-count comparison.
  task automatic access(input logic [63:0] a, input string tag, input int exp_stalls,
                        input int exp_reads);
    int stalls;
    int n0;
    n0     = rd_log.size();
    pc     = a;
    stalls = 0;
    #1;
    while (stall_o !== 1'b0 && stalls < 50) begin
      cyc();
      #1;
      stalls++;
    end
    check_eq({tag, "_served"}, 64'(stall_o), 64'd0);
    check_eq({tag, "_ir"}, 64'(ir), 64'(exp_ir(a)));
    if (exp_stalls >= 0) check_eq({tag, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    check_eq({tag, "_reads"}, 64'(rd_log.size() - n0), 64'(exp_reads));
    cyc();
  endtask

  initial begin
    int n0;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    do_reset("rst0");
    access(64'h1000, "cold", 3, 1);
    check_eq("cold_addr", 64'(rd_log[$]), 64'h80);
    access(64'h1004, "lbhit", 0, 0);
    access(64'h2000, "miss2", 3, 1);
    access(64'h1000, "taghit", 2, 0);

    do_reset("rst1");
    access(64'h1000, "p_f1", 3, 1);
    access(64'h2000, "p_f2", 3, 1);
    access(64'h3000, "p_f3", 3, 1);
    access(64'h4000, "p_f4", 3, 1);
    access(64'h1000, "p_touch", 2, 0);
    access(64'h5000, "p_f5", 3, 1);
    access(64'h1000, "p_keep", 2, 0);
    access(64'h2000, "p_keep2", 2, 0);
    access(64'h4000, "p_keep4", 2, 0);
    access(64'h3000, "p_evicted", 3, 1);

    do_reset("rst2");
    access(64'h101E, "strad", -1, 2);
    check_eq("strad_a0", 64'(rd_log[rd_log.size()-2]), 64'h80);
    check_eq("strad_a1", 64'(rd_log[rd_log.size()-1]), 64'h81);
    access(64'h1020, "post_strad", 0, 0);

    do_reset("rst3");
    access(64'h1000, "fl_pre", 3, 1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    access(64'h1000, "fl_ready", 3, 1);

    n0 = rd_log.size();
    pc = 64'h2000;
    cyc();
    #1;
    check_eq("flf_rd", 64'(bus.b_rd_o), 64'd1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    cyc();
    access(64'h2000, "flf", -1, 1);
    check_eq("flf_total", 64'(rd_log.size() - n0), 64'd2);
    check_eq("flf_a0", 64'(rd_log[rd_log.size()-2]), 64'h100);
    check_eq("flf_a1", 64'(rd_log[rd_log.size()-1]), 64'h100);

    check_eq("addr_stable", 64'(addr_moved), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
